// File: rtl/mips_elastic_pipe_if.sv
// mips_elastic_pipe_if
//   Bundles the handshake, payload, flush, forwarding-lookup and occupancy
//   signals of the elastic pipeline-register chain. The clock and reset
//   stay plain ports on the design.
//   Port summary:
//     in_valid/in_ready/in_data/in_rd/in_wb    upstream entry handshake
//     out_valid/out_ready/out_data/out_rd/out_wb  oldest entry handshake
//     flush[STAGES]                            per-stage kill
//     q_rs1/q_rs2 -> fwd_hit*/fwd_stage*/fwd_data*  forwarding lookup
//     count                                    registered occupancy
//   master modport: the side that feeds and drains the chain.
//   slave modport:  the pipeline chain itself.
interface mips_elastic_pipe_if #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 32,
  parameter int RADDR  = 5
);
  localparam int SW = $clog2(STAGES + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [RADDR-1:0]  in_rd;
  logic              in_wb;
  logic [STAGES-1:0] flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [RADDR-1:0]  out_rd;
  logic              out_wb;
  logic [RADDR-1:0]  q_rs1;
  logic [RADDR-1:0]  q_rs2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [SW-1:0]     fwd_stage1;
  logic [SW-1:0]     fwd_stage2;
  logic [WIDTH-1:0]  fwd_data1;
  logic [WIDTH-1:0]  fwd_data2;
  logic [SW-1:0]     count;

  modport master (
    output in_valid, in_data, in_rd, in_wb, flush, out_ready, q_rs1, q_rs2,
    input  in_ready, out_valid, out_data, out_rd, out_wb,
    input  fwd_hit1, fwd_hit2, fwd_stage1, fwd_stage2, fwd_data1, fwd_data2,
    input  count
  );

  modport slave (
    input  in_valid, in_data, in_rd, in_wb, flush, out_ready, q_rs1, q_rs2,
    output in_ready, out_valid, out_data, out_rd, out_wb,
    output fwd_hit1, fwd_hit2, fwd_stage1, fwd_stage2, fwd_data1, fwd_data2,
    output count
  );
endinterface

// File: rtl/mips_elastic_pipe.sv
// mips_elastic_pipe
//   Parametrised elastic chain of {data, rd, wb} pipeline registers for the
//   MIPS32 core. Stage 0 is the youngest, stage STAGES-1 the oldest. Each
//   stage has its own valid bit; bubbles collapse under backpressure, any
//   stage can be killed by its flush bit, and a two-port lookup returns the
//   youngest in-flight producer of a register.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    mips_elastic_pipe_if.slave (handshakes, flush, lookup, count)
module mips_elastic_pipe #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 32,
  parameter int RADDR  = 5
) (
  input logic                clk,
  input logic                reset,
  mips_elastic_pipe_if.slave bus
);
  localparam int SW = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] wb_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [RADDR-1:0]  rd_q   [STAGES];
  logic [SW-1:0]     count_q;

  logic [STAGES-1:0] ev;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] upstream;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] load;
  logic [SW-1:0]     count_d;

  logic              hit1, hit2;
  logic [SW-1:0]     stage1, stage2;
  logic [WIDTH-1:0]  fdata1, fdata2;

  // A flushed entry behaves as empty in the very cycle it is flushed.
  // A stage can move when it is empty or anything downstream of it can
  // move, so readiness is accumulated from the output end towards stage 0.
  always_comb begin : ready_chain
    logic slack;
    ev    = valid_q & ~bus.flush;
    rdy   = '0;
    slack = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      slack  = slack | ~ev[i];
      rdy[i] = slack;
    end
  end

  // Each stage either takes what sits upstream of it (the input for stage 0)
  // or keeps its own effective valid. Payload only loads for a real entry,
  // so bubbles leave stale data behind harmlessly.
  always_comb begin
    upstream = {ev[STAGES-2:0], bus.in_valid};
    valid_d  = (rdy & upstream) | (~rdy & ev);
    load     = rdy & upstream;
    count_d  = '0;
    for (int i = 0; i < STAGES; i++) begin
      count_d = count_d + SW'(valid_d[i]);
    end
  end

  // State registers; reset drops every entry at once without retiring any.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      wb_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      if (load[0]) begin
        data_q[0] <= bus.in_data;
        rd_q[0]   <= bus.in_rd;
        wb_q[0]   <= bus.in_wb;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          data_q[i] <= data_q[i-1];
          rd_q[i]   <= rd_q[i-1];
          wb_q[i]   <= wb_q[i-1];
        end
      end
    end
  end

  // Forwarding lookup. Scanning from the oldest stage down lets the
  // youngest matching producer overwrite older ones. Register 0 is
  // hard-wired zero in MIPS, so it never forwards.
  always_comb begin
    hit1   = 1'b0;
    stage1 = '0;
    fdata1 = '0;
    hit2   = 1'b0;
    stage2 = '0;
    fdata2 = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (ev[i] && wb_q[i] && (rd_q[i] == bus.q_rs1) && (bus.q_rs1 != '0)) begin
        hit1   = 1'b1;
        stage1 = SW'(i);
        fdata1 = data_q[i];
      end
      if (ev[i] && wb_q[i] && (rd_q[i] == bus.q_rs2) && (bus.q_rs2 != '0)) begin
        hit2   = 1'b1;
        stage2 = SW'(i);
        fdata2 = data_q[i];
      end
    end
  end

  assign bus.in_ready   = rdy[0];
  assign bus.out_valid  = ev[STAGES-1];
  assign bus.out_data   = data_q[STAGES-1];
  assign bus.out_rd     = rd_q[STAGES-1];
  assign bus.out_wb     = wb_q[STAGES-1];
  assign bus.fwd_hit1   = hit1;
  assign bus.fwd_stage1 = stage1;
  assign bus.fwd_data1  = fdata1;
  assign bus.fwd_hit2   = hit2;
  assign bus.fwd_stage2 = stage2;
  assign bus.fwd_data2  = fdata2;
  assign bus.count      = count_q;
endmodule
